mont_param_gen: RTL and testbench

MONT_PARAM_GEN -- requirements
Module: mont_param_gen

---
 rtl/mont_param_gen.sv | 154 +++++++++++++++
 tb/tb_mont_param_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mont_param_gen.sv
// Montgomery parameter generator: for an odd modulus N computes -N^-1 mod 2^W,
// 2^W mod N and 2^(2W) mod N using only shifts, adds and compares.
module mont_param_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] n_prime,
  output logic [W-1:0] r_mod,
  output logic [W-1:0] r2_mod
);

  // state | meaning
  // IDLE  | waiting for start; n captured on acceptance
  // CHK   | cycle 0 registers the validity test, cycle 1 routes on it
  // INV   | bit-serial inverse, i = 1..W-1
  // RED   | 2W shift/subtract steps building 2^W and 2^(2W) mod N
  // DONE  | one-cycle completion pulse; results visible
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CHK  = 3'd1;
  localparam logic [2:0] INV  = 3'd2;
  localparam logic [2:0] RED  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam int XW = W + 1;
  localparam int CW = $clog2(2 * W) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAST_INV = CW'(W - 1);
  localparam logic [CW-1:0] MID_RED  = CW'(W - 1);
  localparam logic [CW-1:0] LAST_RED = CW'(2 * W - 1);

  logic [2:0]    state;
  logic [W-1:0]  n_reg;
  logic [W-1:0]  y;
  logic [W-1:0]  t;
  logic [W-1:0]  n_prime_int;
  logic [W-1:0]  r_mod_int;
  logic [XW-1:0] x;
  logic [CW-1:0] cnt;
  logic          bad;

  logic [W-1:0]  bit_i;
  logic [W-1:0]  n_shl;
  logic [W-1:0]  y_nxt;
  logic [W-1:0]  t_nxt;
  logic [W+1:0]  x_dbl;
  logic [W+1:0]  n_ext;
  logic [XW-1:0] x_nxt;

  // t tracks N*y mod 2^W; clearing bit i of t by adding N<<i keeps it congruent
  // to 1 in the low bits, so y converges to N^-1.
  always_comb begin
    bit_i = W'(1) << cnt;
    n_shl = n_reg << cnt;
    y_nxt = y;
    t_nxt = t;
    if ((t & bit_i) != '0) begin
      y_nxt = y | bit_i;
      t_nxt = t + n_shl;
    end
    x_dbl = {x, 1'b0};
    n_ext = {2'b00, n_reg};
    x_nxt = XW'((x_dbl >= n_ext) ? (x_dbl - n_ext) : x_dbl);
  end

  assign done = (state == DONE);
  // An invalid N drops busy while CHK routes to DONE, so busy spans one cycle.
  assign busy = (state == INV) || (state == RED) ||
                ((state == CHK) && !((cnt == CNT_ONE) && bad));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      n_reg       <= '0;
      y           <= '0;
      t           <= '0;
      x           <= '0;
      cnt         <= '0;
      bad         <= 1'b0;
      n_prime_int <= '0;
      r_mod_int   <= '0;
      err         <= 1'b0;
      n_prime     <= '0;
      r_mod       <= '0;
      r2_mod      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_reg <= n;
            cnt   <= '0;
            state <= CHK;
          end
        end
        CHK: begin
          if (cnt == '0) begin
            bad <= ~n_reg[0] | (n_reg < W'(3));
            y   <= W'(1);
            t   <= n_reg;
            cnt <= CNT_ONE;
          end else if (bad) begin
            err     <= 1'b1;
            n_prime <= '0;
            r_mod   <= '0;
            r2_mod  <= '0;
            cnt     <= '0;
            state   <= DONE;
          end else begin
            state <= INV;
          end
        end
        INV: begin
          y <= y_nxt;
          t <= t_nxt;
          if (cnt == LAST_INV) begin
            n_prime_int <= (~y_nxt) + W'(1);
            x           <= XW'(1);
            cnt         <= '0;
            state       <= RED;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RED: begin
          x   <= x_nxt;
          cnt <= cnt + CNT_ONE;
          if (cnt == MID_RED) begin
            r_mod_int <= x_nxt[W-1:0];
          end
          if (cnt == LAST_RED) begin
            err     <= 1'b0;
            n_prime <= n_prime_int;
            r_mod   <= r_mod_int;
            r2_mod  <= x_nxt[W-1:0];
            cnt     <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_param_gen.sv
// Scoreboard bench for mont_param_gen: directed spec cases, ignored/held start,
// mid-run reset abort and randomized odd moduli against an arithmetic model.
module tb_mont_param_gen;
  localparam int W = 16;
  localparam longint MASK = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] n = '0;
  logic         busy, done, err;
  logic [W-1:0] n_prime, r_mod, r2_mod;

  mont_param_gen #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .n(n),
    .busy(busy), .done(done), .err(err),
    .n_prime(n_prime), .r_mod(r_mod), .r2_mod(r2_mod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] nv;
    logic [W-1:0] np;
    logic [W-1:0] r;
    logic [W-1:0] r2;
    logic         e;
    int           lat;
    int           bcyc;
    longint       t0;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input int nv, input int np, input int r, input int r2, input bit e);
    exp_t x;
    x.nv = W'(nv); x.np = W'(np); x.r = W'(r); x.r2 = W'(r2); x.e = e;
    x.lat = e ? 2 : 3 * W + 1;
    x.bcyc = e ? 1 : 3 * W + 1;
    x.t0 = 0;
    return x;
  endfunction

  // Newton iteration for the inverse, plain modulo for the residues.
  function automatic exp_t model(input logic [W-1:0] nv);
    longint unsigned nn, inv;
    if (nv < 3 || nv[0] == 1'b0) return mk(int'(nv), 0, 0, 0, 1'b1);
    nn = 64'(nv);
    inv = nn;
    for (int k = 0; k < 5; k++) inv = inv * (64'd2 - nn * inv);
    return mk(int'(nv), int'(((64'd1 << W) - (inv & MASK)) & MASK),
              int'((64'd1 << W) % nn), int'((64'd1 << (2 * W)) % nn), 1'b0);
  endfunction

  // Monitor: pops the scoreboard on each done, otherwise checks outputs hold.
  initial begin
    logic [W-1:0] hold_np, hold_r, hold_r2;
    logic hold_err, done_prev;
    int busy_cnt;
    exp_t e;
    hold_np = '0; hold_r = '0; hold_r2 = '0; hold_err = 1'b0;
    done_prev = 1'b0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_np = '0; hold_r = '0; hold_r2 = '0; hold_err = 1'b0;
        done_prev = 1'b0; busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          check("done_single_cycle", done_prev, 0);
          if (sbq.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("n_prime", n_prime, e.np);
            check("r_mod", r_mod, e.r);
            check("r2_mod", r2_mod, e.r2);
            check("err", err, e.e);
            check("busy_at_done", busy, 0);
            check("latency", (longint'($time) - e.t0 - 5) / 10, e.lat);
            check("busy_cycles", busy_cnt, e.bcyc);
            if (!e.e) begin
              check("n_times_nprime", (64'(e.nv) * 64'(n_prime)) & MASK, MASK);
              check("r_lt_n", r_mod < e.nv, 1);
              check("r2_lt_n", r2_mod < e.nv, 1);
            end
            hold_np = e.np; hold_r = e.r; hold_r2 = e.r2; hold_err = e.e;
          end
          busy_cnt = 0;
        end else begin
          check("outputs_hold", {n_prime, r_mod, r2_mod, err}, {hold_np, hold_r, hold_r2, hold_err});
        end
        done_prev = done;
      end
    end
  end

  task automatic launch(input exp_t e);
    @(negedge clk);
    n = e.nv;
    start = 1'b1;
    @(posedge clk);
    e.t0 = longint'($time);
    sbq.push_back(e);
    #1 start = 1'b0;
  endtask

  task automatic pulse_start(input logic [W-1:0] nv);
    @(negedge clk);
    n = nv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("done_timeout", found, 1);
  endtask

  initial begin
    exp_t e, e2;
    bit seen;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_n_prime", n_prime, 0);
    check("reset_r_mod", r_mod, 0);
    check("reset_r2_mod", r2_mod, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    launch(mk(3329, 3327, 2285, 1353, 1'b0)); wait_done();
    launch(mk(7, 37449, 2, 4, 1'b0));         wait_done();
    launch(mk(3328, 0, 0, 0, 1'b1));          wait_done();
    launch(mk(1, 0, 0, 0, 1'b1));             wait_done();
    launch(mk(0, 0, 0, 0, 1'b1));             wait_done();
    launch(mk(2, 0, 0, 0, 1'b1));             wait_done();
    launch(mk(3, 21845, 1, 1, 1'b0));         wait_done();
    launch(mk(65535, 1, 1, 1, 1'b0));         wait_done();

    // start with n=7 mid-run must be dropped, not queued
    launch(mk(3329, 3327, 2285, 1353, 1'b0));
    repeat (9) @(posedge clk);
    #1 n = 16'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; n = '0;
    wait_done();
    launch(mk(7, 37449, 2, 4, 1'b0)); wait_done();

    // start held high: second run accepted on the IDLE cycle after DONE
    @(negedge clk);
    n = 16'd7; start = 1'b1;
    @(posedge clk);
    e = mk(7, 37449, 2, 4, 1'b0);
    e.t0 = longint'($time);
    sbq.push_back(e);
    #1 n = 16'd3329;
    repeat (3 * W + 3) @(posedge clk);
    e2 = mk(3329, 3327, 2285, 1353, 1'b0);
    e2.t0 = longint'($time);
    sbq.push_back(e2);
    #1 start = 1'b0;
    wait_done();

    // reset in the middle of a run aborts it without a done pulse
    pulse_start(16'd3329);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_outputs", {n_prime, r_mod, r2_mod, err}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (80) @(negedge clk) if (done) seen = 1'b1;
    check("no_done_after_abort", seen, 0);
    launch(mk(3329, 3327, 2285, 1353, 1'b0)); wait_done();

    for (int i = 0; i < 1000; i++) begin
      launch(model(W'(($urandom_range(1, 32767) << 1) | 1)));
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
